// File: rtl/cbus_arbiter_rr_pkg.sv
// Shared CBus transaction types and arbiter policy encoding.
package cbus_arbiter_rr_pkg;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic        err;
    logic [31:0] rdata;
  } cbus_resp_t;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;

  // Index width with a floor of one bit so a single-port arbiter still has a grant index.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Wrap-around priority picker: first request at or after start, with one optional port masked.
module cbus_arbiter_rr_pick #(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned IDX_W      = 1
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [IDX_W-1:0]      start,
  input  logic [NUM_INPUTS-1:0] mask_out,
  output logic [IDX_W-1:0]      idx,
  output logic [NUM_INPUTS-1:0] onehot,
  output logic                  any
);

  logic [NUM_INPUTS-1:0]   req_m;
  logic [2*NUM_INPUTS-1:0] req_dbl;

  assign req_m   = req & ~mask_out;
  // Second copy lets a linear scan from start wrap past the top port.
  assign req_dbl = {req_m, req_m};

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < 2 * NUM_INPUTS; i++) begin
      if (!any && (i >= 32'(start)) && req_dbl[i]) begin
        any = 1'b1;
        idx = IDX_W'(i % NUM_INPUTS);
      end
    end
  end

  assign onehot = any ? (NUM_INPUTS'(1) << idx) : '0;

endmodule

// File: rtl/cbus_arbiter_rr.sv
// N-to-1 CBus arbiter, fixed-priority or round-robin, grant held until the response's last beat.
module cbus_arbiter_rr
  import cbus_arbiter_rr_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned RR_MODE    = 1,
  parameter int unsigned MAX_HOLD   = 4,
  localparam int unsigned IDX_W     = idx_width(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  cbus_req_t             ireqs  [NUM_INPUTS],
  output cbus_resp_t            iresps [NUM_INPUTS],
  output cbus_req_t             oreq,
  input  cbus_resp_t            oresp,
  output logic                  busy,
  output logic [IDX_W-1:0]      grant_idx,
  output logic [NUM_INPUTS-1:0] grant_oh
);

  localparam arb_mode_t   Mode   = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;
  localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  logic              busy_q, busy_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]  last_idx_q, last_idx_d;

  logic [NUM_INPUTS-1:0] req_valid, last_oh, mask_out, sel_oh;
  logic [IDX_W-1:0]      start, sel_idx, cur_idx;
  logic                  sel_any, others_valid, hold_block, issue, active, complete;
  logic [HOLD_W-1:0]     hold_inc;

  always_comb begin
    req_valid = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      req_valid[i] = ireqs[i].valid;
    end
  end

  // Once the last owner has used up its hold budget it steps aside, but only if someone waits.
  assign last_oh      = NUM_INPUTS'(1) << last_idx_q;
  assign others_valid = |(req_valid & ~last_oh);
  assign hold_block   = (MAX_HOLD != 0) && (hold_cnt_q >= HOLD_W'(MAX_HOLD)) && others_valid;
  assign mask_out     = hold_block ? last_oh : '0;
  assign start        = (Mode == ARB_RR) ? rr_ptr_q : '0;

  cbus_arbiter_rr_pick #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_W      (IDX_W)
  ) u_pick (
    .req      (req_valid),
    .start    (start),
    .mask_out (mask_out),
    .idx      (sel_idx),
    .onehot   (sel_oh),
    .any      (sel_any)
  );

  assign issue    = !busy_q && sel_any;
  assign active   = busy_q || issue;
  assign cur_idx  = busy_q ? idx_q : sel_idx;
  assign complete = active && oresp.last;
  assign hold_inc = (hold_cnt_q >= HOLD_W'(MAX_HOLD)) ? HOLD_W'(MAX_HOLD) : hold_cnt_q + 1'b1;

  always_comb begin
    oreq      = '0;
    busy      = 1'b0;
    grant_oh  = '0;
    grant_idx = cur_idx;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '0;
    end
    if (reset && active) begin
      oreq            = ireqs[cur_idx];
      iresps[cur_idx] = oresp;
      busy            = 1'b1;
      grant_oh        = busy_q ? (NUM_INPUTS'(1) << idx_q) : sel_oh;
    end
  end

  always_comb begin
    busy_d     = busy_q;
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    last_idx_d = last_idx_q;
    if (!reset) begin
      busy_d     = 1'b0;
      idx_d      = '0;
      rr_ptr_d   = '0;
      hold_cnt_d = '0;
      last_idx_d = '0;
    end else begin
      if (issue) begin
        busy_d = 1'b1;
        idx_d  = sel_idx;
      end
      // Completion wins over issue so a same-cycle last never leaves busy_q set.
      if (complete) begin
        busy_d     = 1'b0;
        rr_ptr_d   = (cur_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : cur_idx + 1'b1;
        hold_cnt_d = (cur_idx == last_idx_q) ? hold_inc : HOLD_W'(1);
        last_idx_d = cur_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    busy_q     <= busy_d;
    idx_q      <= idx_d;
    rr_ptr_q   <= rr_ptr_d;
    hold_cnt_q <= hold_cnt_d;
    last_idx_q <= last_idx_d;
  end

endmodule

// File: tb/tb_cbus_arbiter_rr.sv
// Bench for cbus_arbiter_rr: a round-robin and a fixed-priority instance checked against a model.
module tb_cbus_arbiter_rr;
  import cbus_arbiter_rr_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  cbus_req_t  ireqs [N];
  cbus_resp_t oresp;

  cbus_req_t  oreq_a, oreq_b;
  cbus_resp_t iresps_a [N];
  cbus_resp_t iresps_b [N];
  logic       busy_a, busy_b;
  logic [1:0] gidx_a, gidx_b;
  logic [N-1:0] goh_a, goh_b;

  cbus_arbiter_rr #(.NUM_INPUTS(N), .RR_MODE(1), .MAX_HOLD(4)) dut_rr (
    .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps_a), .oreq(oreq_a),
    .oresp(oresp), .busy(busy_a), .grant_idx(gidx_a), .grant_oh(goh_a)
  );

  cbus_arbiter_rr #(.NUM_INPUTS(N), .RR_MODE(0), .MAX_HOLD(2)) dut_fx (
    .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps_b), .oreq(oreq_b),
    .oresp(oresp), .busy(busy_b), .grant_idx(gidx_b), .grant_oh(goh_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: per-instance arbitration history, index 0 = RR instance, 1 = fixed.
  bit m_busy [2];
  int m_idx  [2];
  int m_ptr  [2];
  int m_hold [2];
  int m_last [2];
  int m_rr   [2] = '{1, 0};
  int m_mh   [2] = '{4, 2};

  int done_a [$];
  int done_b [$];

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int model_sel(int k);
    int  start, excl, j;
    bit  others;
    start  = m_rr[k] ? m_ptr[k] : 0;
    others = 1'b0;
    for (int p = 0; p < N; p++) if (ireqs[p].valid && p != m_last[k]) others = 1'b1;
    excl = (m_mh[k] != 0 && m_hold[k] >= m_mh[k] && others) ? m_last[k] : -1;
    for (int o = 0; o < N; o++) begin
      j = (start + o) % N;
      if (ireqs[j].valid && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic int model_grant(int k);
    if (!reset) return -1;
    return m_busy[k] ? m_idx[k] : model_sel(k);
  endfunction

  task automatic check_outputs();
    cbus_req_t  o_req;
    cbus_resp_t o_rsp [N];
    logic       o_busy;
    logic [1:0] o_gi;
    logic [N-1:0] o_goh;
    string      nm;
    int         g;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        o_req = oreq_a; o_busy = busy_a; o_gi = gidx_a; o_goh = goh_a; nm = "rr";
        for (int j = 0; j < N; j++) o_rsp[j] = iresps_a[j];
      end else begin
        o_req = oreq_b; o_busy = busy_b; o_gi = gidx_b; o_goh = goh_b; nm = "fx";
        for (int j = 0; j < N; j++) o_rsp[j] = iresps_b[j];
      end
      g = model_grant(k);
      chk({nm, ".oreq"}, o_req, (g >= 0) ? ireqs[g] : '0);
      for (int j = 0; j < N; j++)
        chk($sformatf("%s.iresps[%0d]", nm, j), o_rsp[j], (g == j) ? oresp : '0);
      chk({nm, ".grant_oh"}, o_goh, (g >= 0) ? (N'(1) << g) : '0);
      if (reset) chk({nm, ".busy"}, o_busy, (g >= 0));
      if (g >= 0) chk({nm, ".grant_idx"}, o_gi, g);
    end
    if (busy_a === 1'b1 && oresp.last) done_a.push_back(int'(gidx_a));
    if (busy_b === 1'b1 && oresp.last) done_b.push_back(int'(gidx_b));
  endtask

  task automatic model_update();
    int g;
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_busy[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_hold[k] = 0; m_last[k] = 0;
      end else begin
        g = model_grant(k);
        if (g >= 0) begin
          if (oresp.last) begin
            m_busy[k] = 0;
            m_ptr[k]  = (g + 1) % N;
            m_hold[k] = (g == m_last[k]) ? ((m_hold[k] + 1 > m_mh[k]) ? m_mh[k] : m_hold[k] + 1) : 1;
            m_last[k] = g;
          end else begin
            m_busy[k] = 1;
            m_idx[k]  = g;
          end
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic tick();
    settle();
    edge_step();
  endtask

  task automatic set_req(int j, bit v);
    ireqs[j] = '{valid: v, we: 1'($urandom), be: 4'($urandom), addr: $urandom, wdata: $urandom};
  endtask

  task automatic set_resp(bit rdy, bit lst);
    oresp = '{ready: rdy, last: lst, err: 1'($urandom), rdata: $urandom};
  endtask

  task automatic clear_reqs();
    for (int j = 0; j < N; j++) set_req(j, 1'b0);
  endtask

  task automatic do_reset(int n);
    reset = 1'b0;
    clear_reqs();
    set_resp(1'b0, 1'b0);
    repeat (n) tick();
    reset = 1'b1;
  endtask

  int exp_rr   [4] = '{0, 2, 0, 2};
  int exp_fx   [2] = '{1, 2};
  int exp_hold [6] = '{0, 0, 1, 0, 0, 1};

  initial begin
    reset = 1'b0;
    clear_reqs();
    set_resp(1'b0, 1'b0);
    #1;
    do_reset(3);

    // Round-robin: ports 0 and 2 busy, each transfer ends on its second cycle.
    done_a.delete();
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1'b1); set_req(1, 1'b0); set_req(2, 1'b1);
      set_resp(1'b1, m_busy[0]);
      settle();
      if (!m_busy[0]) chk("rr.issue_valid", oreq_a.valid, 1'b1);
      edge_step();
    end
    chk("rr.order_len", done_a.size(), 4);
    for (int i = 0; i < 4 && i < done_a.size(); i++)
      chk($sformatf("rr.order[%0d]", i), done_a[i], exp_rr[i]);

    // Fixed priority: ports 1 and 2 together, port 1 first.
    do_reset(1);
    done_b.delete();
    set_req(1, 1'b1); set_req(2, 1'b1); set_resp(1'b1, 1'b0);
    settle();
    chk("fx.first_grant", gidx_b, 1);
    chk("fx.iresps2_hold0", iresps_b[2], '0);
    edge_step();
    set_req(1, 1'b1); set_req(2, 1'b1); set_resp(1'b1, 1'b1);
    settle();
    chk("fx.iresps2_hold1", iresps_b[2], '0);
    chk("fx.p1_last", iresps_b[1].last, 1'b1);
    edge_step();
    set_req(1, 1'b0); set_req(2, 1'b1); set_resp(1'b1, 1'b0);
    settle();
    chk("fx.second_grant", gidx_b, 2);
    chk("fx.second_valid", oreq_b.valid, 1'b1);
    edge_step();
    set_req(2, 1'b1); set_resp(1'b1, 1'b1);
    tick();
    chk("fx.order_len", done_b.size(), 2);
    for (int i = 0; i < 2 && i < done_b.size(); i++)
      chk($sformatf("fx.order[%0d]", i), done_b[i], exp_fx[i]);

    // Hold limit: port 0 keeps re-requesting, port 1 waits.
    do_reset(1);
    done_b.delete();
    for (int c = 0; c < 12; c++) begin
      set_req(0, 1'b1); set_req(1, 1'b1); set_req(2, 1'b0);
      set_resp(1'b1, m_busy[1]);
      tick();
    end
    chk("hold.order_len", done_b.size(), 6);
    for (int i = 0; i < 6 && i < done_b.size(); i++)
      chk($sformatf("hold.order[%0d]", i), done_b[i], exp_hold[i]);

    // Same-cycle last: the grant completes on its issue cycle.
    do_reset(1);
    clear_reqs();
    set_req(1, 1'b1); set_resp(1'b1, 1'b1);
    settle();
    chk("scl.busy", busy_b, 1'b1);
    chk("scl.last", iresps_b[1].last, 1'b1);
    chk("scl.grant", gidx_b, 1);
    edge_step();
    chk("scl.busy_q0", dut_fx.busy_q, 1'b0);
    set_req(1, 1'b0); set_req(0, 1'b1); set_resp(1'b1, 1'b1);
    settle();
    chk("scl.next_grant", gidx_b, 0);
    chk("scl.next_valid", oreq_b.valid, 1'b1);
    edge_step();
    chk("scl.busy_q1", dut_fx.busy_q, 1'b0);

    // Reset mid-burst: move rr_ptr off zero first, then abort a 4-beat transfer.
    do_reset(1);
    clear_reqs();
    set_req(1, 1'b1); set_resp(1'b1, 1'b1);
    tick();
    chk("rst.ptr_moved", dut_rr.rr_ptr_q, 2);
    clear_reqs();
    for (int c = 0; c < 3; c++) begin
      set_req(0, 1'b1); set_resp(1'b1, 1'b0);
      if (c == 2) reset = 1'b0;
      tick();
    end
    reset = 1'b1;
    clear_reqs();
    settle();
    chk("rst.oreq", oreq_a, '0);
    chk("rst.busy", busy_a, 1'b0);
    chk("rst.grant_oh", goh_a, '0);
    chk("rst.rr_ptr", dut_rr.rr_ptr_q, 0);
    edge_step();

    // Idle: no requests, arbitrary memory-side noise.
    for (int c = 0; c < 10; c++) begin
      clear_reqs();
      set_resp(1'($urandom), 1'($urandom));
      settle();
      chk("idle.oreq", oreq_a, '0);
      chk("idle.busy", busy_a, 1'b0);
      chk("idle.grant_oh", goh_a, '0);
      edge_step();
    end

    // Random traffic, including dropped valids mid-transfer and occasional resets.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(63) != 0);
      for (int j = 0; j < N; j++) set_req(j, 1'($urandom));
      set_resp(1'($urandom), $urandom_range(2) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
